// File: rtl/fft_bitrev_reorder.sv
// Reorders the bit-reversed FFT output stream into natural bin order using ping-pong frame banks.
// Optional build macro FFT_REORDER_MAG_EN adds a registered |re|+|im| output (dout_mag).
module fft_bitrev_reorder #(
  parameter int LOG2N = 6,
  parameter int DW    = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] din_re,
  input  logic signed [DW-1:0] din_im,
  input  logic                 din_valid,
  output logic signed [DW-1:0] dout_re,
  output logic signed [DW-1:0] dout_im,
  output logic                 dout_valid,
  output logic [LOG2N-1:0]     dout_index,
  output logic                 dout_last
`ifdef FFT_REORDER_MAG_EN
  ,
  output logic [DW:0]          dout_mag
`endif
);

  localparam int N = 1 << LOG2N;

  typedef enum logic {IDLE, READ} state_e;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  function automatic logic [DW-1:0] abs_val(input logic signed [DW-1:0] v);
    logic [DW-1:0] u;
    u = v;
    return v[DW-1] ? (~u + DW'(1)) : u;
  endfunction

  logic [2*DW-1:0]   mem_q [2*N];

  logic [LOG2N-1:0]  wr_cnt_q, wr_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic              bank_full;

  state_e            state_q, state_d;
  logic              rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0]  rd_cnt_q, rd_cnt_d;
  logic              rd_vld_q, rd_vld_d;
  logic [LOG2N-1:0]  rd_idx_q, rd_idx_d;
  logic [2*DW-1:0]   rd_word_q, rd_word_d;

  logic signed [DW-1:0] dout_re_q, dout_re_d;
  logic signed [DW-1:0] dout_im_q, dout_im_d;
  logic                 dout_valid_q, dout_valid_d;
  logic [LOG2N-1:0]     dout_index_q, dout_index_d;
  logic                 dout_last_q, dout_last_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    bank_full = 1'b0;
    if (din_valid) begin
      wr_cnt_d = wr_cnt_q + LOG2N'(1);
      if (&wr_cnt_q) begin
        wr_bank_d = ~wr_bank_q;
        bank_full = 1'b1;
      end
    end
  end

  // A readout lasts exactly N cycles and a fill at least N, so a new bank_full
  // can only coincide with the final read address (seamless back-to-back).
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_cnt_d  = rd_cnt_q;
    case (state_q)
      IDLE: begin
        if (bank_full) begin
          state_d   = READ;
          rd_bank_d = wr_bank_q;
          rd_cnt_d  = '0;
        end
      end
      READ: begin
        rd_cnt_d = rd_cnt_q + LOG2N'(1);
        if (&rd_cnt_q) begin
          state_d = IDLE;
          if (bank_full) begin
            state_d   = READ;
            rd_bank_d = wr_bank_q;
            rd_cnt_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_vld_d  = (state_q == READ);
    rd_idx_d  = rd_cnt_q;
    rd_word_d = mem_q[{rd_bank_q, rd_cnt_q}];
  end

  always_comb begin
    dout_valid_d = rd_vld_q;
    dout_re_d    = dout_re_q;
    dout_im_d    = dout_im_q;
    dout_index_d = dout_index_q;
    dout_last_d  = dout_last_q;
    if (rd_vld_q) begin
      dout_re_d    = rd_word_q[2*DW-1:DW];
      dout_im_d    = rd_word_q[DW-1:0];
      dout_index_d = rd_idx_q;
      dout_last_d  = &rd_idx_q;
    end
  end

  // NOTE: frame storage and its read word carry no reset; every location is
  // rewritten before it is read, so resetting them would only cost logic.
  always_ff @(posedge clk) begin
    if (din_valid) mem_q[{wr_bank_q, bitrev(wr_cnt_q)}] <= {din_re, din_im};
    rd_word_q <= rd_word_d;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt_q     <= '0;
      wr_bank_q    <= 1'b0;
      state_q      <= IDLE;
      rd_bank_q    <= 1'b0;
      rd_cnt_q     <= '0;
      rd_vld_q     <= 1'b0;
      rd_idx_q     <= '0;
      dout_re_q    <= '0;
      dout_im_q    <= '0;
      dout_valid_q <= 1'b0;
      dout_index_q <= '0;
      dout_last_q  <= 1'b0;
    end else begin
      wr_cnt_q     <= wr_cnt_d;
      wr_bank_q    <= wr_bank_d;
      state_q      <= state_d;
      rd_bank_q    <= rd_bank_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_vld_q     <= rd_vld_d;
      rd_idx_q     <= rd_idx_d;
      dout_re_q    <= dout_re_d;
      dout_im_q    <= dout_im_d;
      dout_valid_q <= dout_valid_d;
      dout_index_q <= dout_index_d;
      dout_last_q  <= dout_last_d;
    end
  end

  assign dout_re    = dout_re_q;
  assign dout_im    = dout_im_q;
  assign dout_valid = dout_valid_q;
  assign dout_index = dout_index_q;
  assign dout_last  = dout_last_q;

`ifdef FFT_REORDER_MAG_EN
  logic [DW:0] dout_mag_q, dout_mag_d;

  // Unsigned DW-bit magnitudes keep |-2^(DW-1)| exact before the widening add.
  always_comb begin
    dout_mag_d = dout_mag_q;
    if (rd_vld_q)
      dout_mag_d = {1'b0, abs_val(rd_word_q[2*DW-1:DW])} + {1'b0, abs_val(rd_word_q[DW-1:0])};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) dout_mag_q <= '0;
    else        dout_mag_q <= dout_mag_d;
  end

  assign dout_mag = dout_mag_q;
`endif

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Output-side reorder buffer for the radix-2 DIF FFT core. It accepts the core's complex output stream, which arrives in bit-reversed bin order, and re-emits each frame in natural bin order as a burst tagged with bin index and frame-end marker. It sits directly downstream of the FFT core's dout_re/dout_im/dout_valid port and tolerates arbitrary gaps in the input valid. Storage is a pair of ping-pong frame buffers, so one frame can be written while the previous frame is read out.

## Interface
Parameters:
- LOG2N, 6: log2 of frame length N (64 points).
- DW, 17: signed sample width per component; matches the FFT core output width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- din_re  in  DW  signed real part, bit-reversed order.
- din_im  in  DW  signed imaginary part.
- din_valid  in  1  sample accepted on any edge where high; no backpressure.
- dout_re  out  DW  signed real part, natural order.
- dout_im  out  DW  signed imaginary part.
- dout_valid  out  1  output sample valid.
- dout_index  out  LOG2N  bin index n of the current output.
- dout_last  out  1  high with bin N-1.
- dout_mag  out  DW+1  |re|+|im|; present only with FFT_REORDER_MAG_EN.

## Operation
- Storage: two banks of N x 2·DW. Writes use wr_bank, reads use rd_bank.
- Write side: wr_cnt runs 0..N-1 and advances only on din_valid.
  - Sample k of a frame is written to address bitrev(k) of wr_bank.
  - At wr_cnt=N-1 with din_valid: wr_cnt wraps to 0, wr_bank toggles, and a bank_full pulse fires for the completed bank.
- Read FSM states:
  - IDLE: on bank_full, latch rd_bank = completed bank, set rd_cnt=0, go to READ.
  - READ: issue address rd_cnt and increment it each cycle.
  - At rd_cnt=N-1, go to IDLE. If bank_full is also asserted that cycle, go back to READ with the new bank and rd_cnt=0 (back-to-back frames).
- Output register: loaded one cycle after address issue.
  - dout_index = issued rd_cnt.
  - dout_last = (index==N-1).
  - dout_re/dout_im/dout_index/dout_last hold their last value when dout_valid is low.
- Overrun cannot occur: filling a bank takes at least N cycles and a readout takes exactly N. The verification bench asserts this: bank_full never fires while READ has rd_cnt<N-1.
- Reset values: all outputs 0, wr_cnt=0, wr_bank=0, rd_cnt=0, FSM=IDLE. Memory contents are not reset.
- Reset mid-frame: any partial write frame and any in-progress readout are discarded. The first frame after reset starts at k=0.

## Timing
- If the last sample of a frame is accepted at edge E, the first natural-order output (index 0) registers at edge E+2.
- Outputs then continue on N consecutive cycles, ending at E+N+1 with dout_last.
- Output bursts never have gaps. Input gaps affect only when a burst starts.
- Back-to-back input (din_valid held high for 2N cycles) gives 2N consecutive output cycles with no idle cycle between frames.
- Throughput: one sample per cycle sustained.

## Configuration
- FFT_REORDER_MAG_EN defined:
  - Adds the dout_mag port = |dout_re|+|dout_im|, unsigned, DW+1 bits, registered on the same edge as dout_re, so the latency is unchanged.
  - |−2^(DW−1)| is represented exactly.
  - dout_mag resets to 0.
- FFT_REORDER_MAG_EN not defined: the port, adders and register are absent. All other behaviour is identical.

## Test plan
- Ramp frame: din_re=k, din_im=−k for k=0..63, contiguous. Required output: index 0 → re 0; index 1 → re 32, im −32; index 2 → re 16; index 63 → re 63. dout_last only on index 63. First dout_valid 2 cycles after the last input.
- Gapped input: same frame with din_valid low for 3 cycles after every 5th sample. Output data is identical to the ramp case. The burst stays 64 contiguous cycles, starting 2 cycles after the final accepted sample.
- Back-to-back: 128 contiguous samples, frame 2 = frame 1 + 100 on re. Required: 128 contiguous dout_valid cycles; index wraps 63→0 with no gap; frame-2 index 1 re = 132.
- Reset mid-frame: 30 samples, rst_n low 2 cycles, then a full 64-sample ramp. Required: exactly one 64-cycle burst containing ramp data only. All outputs read 0 during reset.
- Reset mid-readout: assert rst_n at output index 20. Required: dout_valid=0 from the next edge, and no further outputs until a new full frame arrives.
- Magnitude (macro on): din_re=−5, din_im=3 at k=0; din_re=−65536, din_im=−65536 at k=1. Required: index 0 dout_mag=8; index 32 dout_mag=131072.
